// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } digit_e;

  // Digits needed to cover a WIDTH+2 bit extended multiplier.
  function automatic int unsigned iter_count(input int unsigned width);
    return width / 2 + 1;
  endfunction

  function automatic digit_e booth_decode(input logic [2:0] triplet);
    case (triplet)
      3'b001, 3'b010: return POS1;
      3'b011:         return POS2;
      3'b100:         return NEG2;
      3'b101, 3'b110: return NEG1;
      default:        return ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_r4_digit_sel.sv
// Radix-4 Booth digit selection: maps a multiplier triplet to 0, +-M or +-2M.
module booth_r4_digit_sel
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]       triplet_i,
  input  logic [WIDTH+1:0] m_i,
  output logic [WIDTH+2:0] pp_c
);

  localparam int unsigned PW = WIDTH + 3;

  logic [PW-1:0] m1;
  logic [PW-1:0] m2;
  digit_e        digit;

  assign m1    = {m_i[WIDTH+1], m_i};
  assign m2    = {m_i, 1'b0};
  assign digit = booth_decode(triplet_i);

  always_comb begin
    pp_c = '0;
    case (digit)
      POS1:    pp_c = m1;
      POS2:    pp_c = m2;
      NEG1:    pp_c = PW'(0) - m1;
      NEG2:    pp_c = PW'(0) - m2;
      default: pp_c = '0;
    endcase
  end

endmodule

// File: rtl/booth_radix4_mult.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per operation,
// fixed latency of WIDTH/2+1 cycles from the accepting edge to done.
module booth_radix4_mult
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               done,
  output logic               busy
);

  localparam int unsigned EW   = WIDTH + 2;
  localparam int unsigned HW   = EW + 1;
  localparam int unsigned AW   = 2 * EW + 1;
  localparam int unsigned PRW  = 2 * WIDTH;
  localparam int unsigned ITER = iter_count(WIDTH);
  localparam int unsigned CW   = $clog2(ITER);

  if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("booth_radix4_mult: WIDTH must be even and at least 4");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [EW-1:0]   m_q, m_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic            bm1_q, bm1_d;
  logic [PRW-1:0]  p_q, p_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic [EW-1:0]   a_ext;
  logic [EW-1:0]   b_ext;
  logic [HW-1:0]   pp;
  logic [HW-1:0]   sum;
  logic signed [AW-1:0] acc_sum;
  logic [AW-1:0]   acc_shift;

  assign a_ext = signed_mode ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
  assign b_ext = signed_mode ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};

  booth_r4_digit_sel #(
    .WIDTH(WIDTH)
  ) u_digit_sel (
    .triplet_i({acc_q[1:0], bm1_q}),
    .m_i      (m_q),
    .pp_c     (pp)
  );

  // Upper part takes the partial product; the low part still holds the
  // unconsumed multiplier bits, which shift out two per cycle.
  assign sum       = acc_q[AW-1:EW] + pp;
  assign acc_sum   = {sum, acc_q[EW-1:0]};
  assign acc_shift = acc_sum >>> 2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      bm1_q   <= 1'b0;
      p_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      bm1_q   <= bm1_d;
      p_q     <= p_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    acc_d   = acc_q;
    bm1_d   = bm1_q;
    p_d     = p_q;
    done_d  = done_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d     = a_ext;
          acc_d   = {HW'(0), b_ext};
          bm1_d   = 1'b0;
          cnt_d   = '0;
          p_d     = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_shift;
        bm1_d = acc_q[1];
        if (cnt_q == CW'(ITER - 1)) begin
          p_d     = acc_shift[PRW-1:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign P    = p_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Directed-vector bench for booth_radix4_mult at WIDTH=8, plus WIDTH=4
// exhaustive and WIDTH=16 random products against the behavioural multiply.
module tb_booth_radix4_mult;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;
  logic        done8, busy8;

  logic        start4 = 1'b0, sm4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  p4;
  logic        done4, busy4;

  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] p16;
  logic        done16, busy16;

  booth_radix4_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .A(a8), .B(b8), .P(p8), .done(done8), .busy(busy8)
  );

  booth_radix4_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
    .A(a4), .B(b4), .P(p4), .done(done4), .busy(busy4)
  );

  booth_radix4_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
    .A(a16), .B(b16), .P(p16), .done(done16), .busy(busy16)
  );

  typedef struct {
    logic        sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[13];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive start for one edge; returns just after the accepting edge.
  task automatic launch8(input logic sm, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    sm8 = sm; a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // Counts edges until done (bounded) and samples busy along the way.
  task automatic wait_done8(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done8 && lat < 20) begin
      if (busy8) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op4(input logic sm, input logic [3:0] a, input logic [3:0] b, output int lat);
    @(negedge clk);
    sm4 = sm; a4 = a; b4 = b; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op16(input logic sm, input logic [15:0] a, input logic [15:0] b, output int lat);
    @(negedge clk);
    sm16 = sm; a16 = a; b16 = b; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0;
    while (!done16 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, bc;
    logic [3:0]  ua4, ub4;
    logic [15:0] ra, rb;
    logic signed [7:0]  sp8;
    logic signed [31:0] sp32;
    logic [7:0]  e4;
    logic [31:0] e16;

    vecs[0]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[1]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[2]  = '{1'b0, 8'hC8, 8'h03, 16'h0258};
    vecs[3]  = '{1'b1, 8'hC8, 8'h03, 16'hFF58};
    vecs[4]  = '{1'b1, 8'h7F, 8'h80, 16'hC080};
    vecs[5]  = '{1'b1, 8'h01, 8'hFF, 16'hFFFF};
    vecs[6]  = '{1'b1, 8'h00, 8'h00, 16'h0000};
    vecs[7]  = '{1'b0, 8'h07, 8'h09, 16'h003F};
    vecs[8]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
    vecs[9]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[10] = '{1'b0, 8'hFF, 8'h01, 16'h00FF};
    vecs[11] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
    vecs[12] = '{1'b0, 8'hC8, 8'hFF, 16'hC738};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset P", 32'(p8), 32'h0);
    check("reset done", 32'(done8), 32'h0);
    check("reset busy", 32'(busy8), 32'h0);

    foreach (vecs[i]) begin
      launch8(vecs[i].sm, vecs[i].a, vecs[i].b);
      check("busy after accept", 32'(busy8), 32'h1);
      wait_done8(lat, bc);
      check($sformatf("vec%0d P", i), 32'(p8), 32'(vecs[i].exp));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd5);
      check($sformatf("vec%0d busy cycles", i), 32'(bc), 32'd5);
      check($sformatf("vec%0d busy at done", i), 32'(busy8), 32'h0);
    end

    // start mid-RUN with different operands must be ignored
    launch8(1'b0, 8'h03, 8'h05);
    @(posedge clk); #1;
    @(negedge clk);
    sm8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(lat, bc);
    check("midrun P", 32'(p8), 32'h000F);
    check("midrun latency", 32'(lat + 2), 32'd5);

    // restart from DONE: done and P clear on the accepting edge
    launch8(1'b0, 8'h02, 8'h03);
    check("restart done drop", 32'(done8), 32'h0);
    check("restart busy", 32'(busy8), 32'h1);
    check("restart P clear", 32'(p8), 32'h0);
    wait_done8(lat, bc);
    check("restart P", 32'(p8), 32'h0006);
    check("restart latency", 32'(lat), 32'd5);

    // reset sampled on the edge ending the 3rd RUN cycle
    launch8(1'b0, 8'h11, 8'h11);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort P", 32'(p8), 32'h0);
    check("abort done", 32'(done8), 32'h0);
    check("abort busy", 32'(busy8), 32'h0);
    repeat (6) @(posedge clk);
    #1;
    check("abort stays idle", 32'(done8), 32'h0);
    launch8(1'b0, 8'h07, 8'h09);
    wait_done8(lat, bc);
    check("post-abort P", 32'(p8), 32'd63);
    check("post-abort latency", 32'(lat), 32'd5);

    // WIDTH=4 exhaustive, both modes
    for (int m = 0; m < 2; m++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          ua4 = 4'(ia);
          ub4 = 4'(ib);
          if (m == 1) begin
            sp8 = $signed(ua4) * $signed(ub4);
            e4  = 8'(sp8);
          end else begin
            e4  = 8'(ia * ib);
          end
          op4(1'(m), ua4, ub4, lat);
          check($sformatf("w4 m%0d %0d*%0d", m, ia, ib), {lat[23:0], p4}, {24'd3, e4});
        end
      end
    end

    // WIDTH=16 random pairs, both modes
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 2000; k++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        if (m == 1) begin
          sp32 = $signed(ra) * $signed(rb);
          e16  = 32'(sp32);
        end else begin
          e16  = 32'(ra) * 32'(rb);
        end
        op16(1'(m), ra, rb, lat);
        check($sformatf("w16 m%0d 0x%0h*0x%0h", m, ra, rb), p16, e16);
        if (lat != 9) check("w16 latency", 32'(lat), 32'd9);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
